// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared constants and types for the branch-resolution
// controller and its predictor-update queue.
//   InstAddrBus   - instruction address width
//   ZeroWord      - all-zero address
//   True/False    - single-bit truth constants
//   bc_state_t    - flush FSM state encoding (BC_IDLE / BC_FLUSH)
//   upd_entry_t   - one predictor training record {pc, dest, taken}
package branch_ctrl_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam logic [InstAddrBus-1:0] ZeroWord = '0;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic {
    BC_IDLE  = 1'b0,
    BC_FLUSH = 1'b1
  } bc_state_t;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstAddrBus-1:0] dest;
    logic                   taken;
  } upd_entry_t;

  localparam int unsigned UpdWidth = $bits(upd_entry_t);

endpackage

// File: rtl/branch_ctrl_upd_fifo.sv
// upd_fifo: generic synchronous FIFO.
//   clk, rst     - clock and synchronous active-high reset (empties the FIFO)
//   push, din    - write request and data
//   pop          - read request (head advances)
//   dout         - head entry (valid only while !empty)
//   full, empty  - occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module upd_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves EX-stage control flow against the carried prediction,
// issues a timed flush plus redirect to IF on mispredict, queues predictor
// training writes and counts mispredictions.
//   clk, rst                      - clock, synchronous active-high reset
//   ex_valid/ex_pc/ex_is_jmp/...  - resolved EX instruction and its prediction
//   stall_req                     - combinational hold of EX (update queue full)
//   flush                         - squash IF/ID/EX for FLUSH_CYCLES cycles
//   redirect_valid/redirect_pc    - one-cycle fetch redirect
//   upd_valid/upd_pc/upd_dest/upd_taken, upd_ready - predictor update port
//   mispred_cnt                   - saturating mispredict counter
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic [InstAddrBus-1:0] ex_pc,
  input  logic                   ex_is_jmp,
  input  logic                   ex_taken,
  input  logic [InstAddrBus-1:0] ex_dest,
  input  logic                   ex_pred_taken,
  input  logic [InstAddrBus-1:0] ex_pred_dest,
  output logic                   stall_req,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [InstAddrBus-1:0] redirect_pc,
  output logic                   upd_valid,
  output logic [InstAddrBus-1:0] upd_pc,
  output logic [InstAddrBus-1:0] upd_dest,
  output logic                   upd_taken,
  input  logic                   upd_ready,
  output logic [31:0]            mispred_cnt
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bc_state_t              state;
  logic [CW-1:0]          flush_cnt;
  logic                   live;
  logic                   mispredict;
  logic                   accept_mis;
  logic [InstAddrBus-1:0] target;
  logic                   q_push;
  logic                   q_pop;
  logic                   q_full;
  logic                   q_empty;
  upd_entry_t             q_din;
  upd_entry_t             q_head;

  always_comb begin
    live       = ex_valid && !flush;
    stall_req  = ex_valid && ex_is_jmp && !flush && q_full && !upd_ready;
    mispredict = ex_is_jmp ? ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_pred_dest != ex_dest)))
                           : ex_pred_taken;
    accept_mis = live && !stall_req && mispredict;
    target     = (ex_is_jmp && ex_taken) ? ex_dest : ex_pc + 32'd4;
    q_push     = live && ex_is_jmp && !stall_req;
    q_din      = '{pc: ex_pc, dest: ex_dest, taken: ex_taken};
    upd_valid  = !q_empty;
    q_pop      = upd_valid && upd_ready;
    // Present zeros while empty so the port is clean even though storage is unreset.
    upd_pc     = upd_valid ? q_head.pc    : ZeroWord;
    upd_dest   = upd_valid ? q_head.dest  : ZeroWord;
    upd_taken  = upd_valid ? q_head.taken : False;
  end

  upd_fifo #(
    .WIDTH (UpdWidth),
    .DEPTH (QDEPTH)
  ) u_upd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BC_IDLE;
      flush_cnt      <= '0;
      flush          <= False;
      redirect_valid <= False;
      redirect_pc    <= ZeroWord;
      mispred_cnt    <= '0;
    end else begin
      case (state)
        BC_IDLE: begin
          if (accept_mis) begin
            state          <= BC_FLUSH;
            flush_cnt      <= CW'(FLUSH_CYCLES - 1);
            flush          <= True;
            redirect_valid <= True;
            redirect_pc    <= target;
            if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
          end
        end
        BC_FLUSH: begin
          redirect_valid <= False;
          if (flush_cnt == '0) begin
            state <= BC_IDLE;
            flush <= False;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state <= BC_IDLE;
          flush <= False;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_jmp;
  logic        ex_taken;
  logic [31:0] ex_dest;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_dest;
  logic        stall_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_dest;
  logic        upd_taken;
  logic        upd_ready;
  logic [31:0] mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_ctrl #(.QDEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_jmp      (ex_is_jmp),
    .ex_taken       (ex_taken),
    .ex_dest        (ex_dest),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_dest   (ex_pred_dest),
    .stall_req      (stall_req),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_dest       (upd_dest),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic jmp,
                        input logic tk, input logic [31:0] dst,
                        input logic ptk, input logic [31:0] pdst);
    ex_valid = v; ex_pc = pc; ex_is_jmp = jmp; ex_taken = tk;
    ex_dest = dst; ex_pred_taken = ptk; ex_pred_dest = pdst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_ready = 1'b1;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
    total++; if ({upd_pc, upd_dest, upd_taken} !== 65'h0) begin bad++; $display("FAIL reset_upd_data: got %h %h %b want 0", upd_pc, upd_dest, upd_taken); end
    total++; if (mispred_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", mispred_cnt); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    next_cycle();
  endtask

  task automatic test_correct();
    upd_ready = 1'b1;
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    @(negedge clk);
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL correct_stall: got %b want 0", stall_req); end
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL correct_flush: got %b want 0", flush); end
    total++; if (mispred_cnt !== 32'h0) begin bad++; $display("FAIL correct_cnt: got %0d want 0", mispred_cnt); end
    total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL correct_upd_valid: got %b want 1", upd_valid); end
    total++; if ({upd_pc, upd_dest, upd_taken} !== {32'h100, 32'h200, 1'b1}) begin bad++; $display("FAIL correct_upd_data: got %h %h %b want 100 200 1", upd_pc, upd_dest, upd_taken); end
    next_cycle();
    @(negedge clk);
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL correct_drained: got %b want 0", upd_valid); end
    next_cycle();
  endtask

  task automatic test_direction();
    logic [3:0] fl;
    logic [3:0] rv;
    upd_ready = 1'b1;
    set_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    @(negedge clk);
    fl[0] = flush; rv[0] = redirect_valid;
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL dir_rpc: got %h want 80", redirect_pc); end
    total++; if (mispred_cnt !== 32'd1) begin bad++; $display("FAIL dir_cnt: got %0d want 1", mispred_cnt); end
    total++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== {1'b1, 32'h40, 32'h80, 1'b1}) begin bad++; $display("FAIL dir_enqueue: got %b %h %h %b want 1 40 80 1", upd_valid, upd_pc, upd_dest, upd_taken); end
    for (int i = 1; i < 4; i++) begin
      if (i > 1) @(negedge clk);
      fl[i] = flush; rv[i] = redirect_valid;
      next_cycle();
    end
    total++; if (fl !== 4'b0110) begin bad++; $display("FAIL dir_flush_window: got %b want 0110", fl); end
    total++; if (rv !== 4'b0010) begin bad++; $display("FAIL dir_redirect_window: got %b want 0010", rv); end
  endtask

  task automatic test_alias_wrap();
    upd_ready = 1'b1;
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234, 1'b1, 32'h5678);
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    total++; if ({flush, redirect_valid} !== 2'b11) begin bad++; $display("FAIL alias_flush: got %b%b want 11", flush, redirect_valid); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL alias_rpc_wrap: got %h want 0", redirect_pc); end
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL alias_no_enqueue: got %b want 0", upd_valid); end
    total++; if (mispred_cnt !== 32'd2) begin bad++; $display("FAIL alias_cnt: got %0d want 2", mispred_cnt); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL alias_flush_end: got %b want 0", flush); end
    next_cycle();
  endtask

  task automatic test_mispred_during_flush();
    upd_ready = 1'b1;
    set_ex(1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
    next_cycle();
    set_ex(1'b1, 32'h504, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    @(negedge clk);
    total++; if ({flush, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 32'h600}) begin bad++; $display("FAIL fl2_first: got %b %b %h want 1 1 600", flush, redirect_valid, redirect_pc); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL fl2_stall_gated: got %b want 0", stall_req); end
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL fl2_no_redirect: got %b want 0", redirect_valid); end
    total++; if (redirect_pc !== 32'h600) begin bad++; $display("FAIL fl2_rpc: got %h want 600", redirect_pc); end
    total++; if (mispred_cnt !== 32'd3) begin bad++; $display("FAIL fl2_cnt: got %0d want 3", mispred_cnt); end
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL fl2_no_enqueue: got %b want 0", upd_valid); end
    next_cycle();
    @(negedge clk);
    total++; if ({flush, redirect_valid, mispred_cnt} !== {1'b0, 1'b0, 32'd3}) begin bad++; $display("FAIL fl2_after: got %b %b %0d want 0 0 3", flush, redirect_valid, mispred_cnt); end
    next_cycle();
  endtask

  task automatic test_queue_full();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, 32'h1000 + 32'(4*i), 1'b1, 1'b1, 32'h2000 + 32'(16*i), 1'b1, 32'h2000 + 32'(16*i));
      @(negedge clk);
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL full_fill_stall%0d: got %b want 0", i, stall_req); end
      next_cycle();
    end
    set_ex(1'b1, 32'h1010, 1'b1, 1'b1, 32'h2040, 1'b1, 32'h2040);
    @(negedge clk);
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL full_stall: got %b want 1", stall_req); end
    next_cycle();
    @(negedge clk);
    total++; if ({stall_req, upd_valid, upd_pc} !== {1'b1, 1'b1, 32'h1000}) begin bad++; $display("FAIL full_hold: got %b %b %h want 1 1 1000", stall_req, upd_valid, upd_pc); end
    next_cycle();
    upd_ready = 1'b1;
    #1;
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL full_release: got %b want 0", stall_req); end
    @(negedge clk);
    total++; if (upd_pc !== 32'h1000) begin bad++; $display("FAIL full_head0: got %h want 1000", upd_pc); end
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      total++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== {1'b1, 32'h1000 + 32'(4*k), 32'h2000 + 32'(16*k), 1'b1}) begin
        bad++; $display("FAIL full_drain%0d: got %b %h %h %b want 1 %h %h 1", k, upd_valid, upd_pc, upd_dest, upd_taken, 32'h1000 + 32'(4*k), 32'h2000 + 32'(16*k));
      end
      next_cycle();
    end
    @(negedge clk);
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", upd_valid); end
    total++; if (mispred_cnt !== 32'd3) begin bad++; $display("FAIL full_cnt: got %0d want 3", mispred_cnt); end
    next_cycle();
  endtask

  task automatic test_reset_mid_flush();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h800 + 32'(4*i), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      next_cycle();
    end
    set_ex(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    next_cycle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({flush, upd_valid, upd_pc, redirect_pc, mispred_cnt} !== {1'b1, 1'b1, 32'h800, 32'h904, 32'd4}) begin
      bad++; $display("FAIL rstmid_pre: got %b %b %h %h %0d want 1 1 800 904 4", flush, upd_valid, upd_pc, redirect_pc, mispred_cnt);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++; if ({flush, redirect_valid, redirect_pc, mispred_cnt} !== 66'h0) begin bad++; $display("FAIL rstmid_ctrl: got %b %b %h %0d want 0 0 0 0", flush, redirect_valid, redirect_pc, mispred_cnt); end
    total++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== 66'h0) begin bad++; $display("FAIL rstmid_queue: got %b %h %h %b want 0", upd_valid, upd_pc, upd_dest, upd_taken); end
    next_cycle();
    @(negedge clk);
    total++; if ({flush, upd_valid} !== 2'b00) begin bad++; $display("FAIL rstmid_after: got %b%b want 00", flush, upd_valid); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_direction();
    test_alias_wrap();
    test_mispred_during_flush();
    test_queue_full();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution and predictor-training controller between EX and IF. Compares each EX-stage control-flow outcome with the prediction carried down the pipe. On a mismatch it issues a timed flush plus a redirect PC to IF. It also serializes training writes into the branch predictor through a small update queue, and counts mispredictions.

## Interface

Parameters:
- `QDEPTH`, default 4: update-queue entries (power of two, ≥2).
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high per mispredict (≥1).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. One clock; synchronous, active-high.
- `ex_valid`  in  1: EX holds a live instruction.
- `ex_pc`  in  32: PC of the EX instruction.
- `ex_is_jmp`  in  1: instruction is a branch or jump.
- `ex_taken`  in  1: resolved direction.
- `ex_dest`  in  32: resolved target.
- `ex_pred_taken`  in  1: prediction carried from IF.
- `ex_pred_dest`  in  32: predicted target carried from IF.
- `stall_req`  out  1: holds EX; combinational.
- `flush`  out  1: squash IF/ID/EX.
- `redirect_valid`  out  1: one-cycle redirect strobe to IF.
- `redirect_pc`  out  32: fetch address for IF.
- `upd_valid`  out  1: predictor update port, drives `is_jmp`.
- `upd_pc`  out  32: update PC.
- `upd_dest`  out  32: update target.
- `upd_taken`  out  1: update direction, drives `jmp_res`.
- `upd_ready`  in  1: predictor accepts an update this cycle. Tie high when the port is exclusive.
- `mispred_cnt`  out  32: saturating mispredict counter.

## Operation

- Live instruction: `ex_valid && !flush`. While `flush` is high, EX inputs are ignored entirely.
- Mispredict, branch case: `ex_is_jmp` and either `ex_taken != ex_pred_taken`, or (`ex_taken && ex_pred_dest != ex_dest`).
- Mispredict, alias case: `!ex_is_jmp && ex_pred_taken`.
- Redirect target: `ex_dest` if the instruction is a taken jump; otherwise `ex_pc + 32'd4`. Addition wraps modulo 2^32.
- Flush FSM, state `IDLE`: a live mispredict with `!stall_req` loads `redirect_pc` and moves to `FLUSH`. The flush-cycle counter is loaded with `FLUSH_CYCLES-1`.
- Flush FSM, state `FLUSH`: `flush` = 1. `redirect_valid` = 1 on the first `FLUSH` cycle only. The counter decrements each cycle; leave for `IDLE` when it is 0 at the edge.
- Update queue (FIFO, `QDEPTH` entries): every live `ex_is_jmp` without `stall_req` enqueues {pc, dest, taken}. Alias mispredicts do not enqueue.
- Dequeue: the head is presented on `upd_*` whenever the queue is non-empty. It pops on `upd_valid && upd_ready`.
- Full: `stall_req` = `ex_valid && ex_is_jmp && !flush && full && !upd_ready`. Full with a same-cycle pop means the enqueue is accepted and occupancy is unchanged.
- A stalled mispredict is not acted on until the stall clears. Redirect and enqueue then occur in the same cycle.
- `mispred_cnt` increments once per accepted mispredict and saturates at 0xFFFF_FFFF.

## Timing

- Reset values: `flush`=0, `redirect_valid`=0, `redirect_pc`=0, `upd_valid`=0, `upd_pc`=0, `upd_dest`=0, `upd_taken`=0, `mispred_cnt`=0, queue empty, FSM `IDLE`.
- Reset applied mid-flush or with a non-empty queue: everything returns to the reset values above at the next edge, and queued entries are discarded.
- A mispredict resolved in EX at cycle N gives `flush`/`redirect_valid` in cycles N+1 … N+`FLUSH_CYCLES`. `redirect_valid` is high in N+1 only.
- Enqueue at the edge ending cycle N → `upd_valid` in N+1 if the queue was empty. Minimum training latency is one cycle.
- Queue throughput is one update per cycle. Order is strictly FIFO.
- `stall_req` is purely combinational from inputs and current occupancy. It has no dependence on `flush` beyond the `!flush` gating term.
- A new mispredict arriving during `FLUSH` is ignored: it is squashed work.

## Structure

- Shared package/defines: `InstAddrBus` width (32), `ZeroWord`, `True`/`False`, and the FSM state encoding `BC_IDLE`/`BC_FLUSH`.
- One natural sub-module: `upd_fifo`, a generic synchronous FIFO parameterized by width (65) and depth. It exposes `push`, `pop`, `full`, `empty` and the head data. The FSM, compare logic and counter stay in `branch_ctrl`.

## Test plan

- Correct prediction: taken jump pc=0x100, dest=0x200, prediction taken with 0x200 → no flush, `mispred_cnt`=0. Next cycle `upd_valid`=1 with pc=0x100, dest=0x200, taken=1.
- Direction mispredict: pc=0x40, taken, dest=0x80, predicted not-taken → `flush` high exactly 2 cycles, `redirect_valid` 1 cycle, `redirect_pc`=0x80, `mispred_cnt`=1.
- Alias plus wrap: non-jump pc=0xFFFF_FFFC with `ex_pred_taken`=1 → `redirect_pc`=0x0000_0000, nothing enqueued.
- Queue full: `upd_ready`=0 and 5 consecutive jumps → 4 enqueued, 5th raises `stall_req`. Raising `upd_ready` → stall drops that cycle and entries drain in order.
- Mispredict during flush: a second mispredict (target 0x300) presented in the `FLUSH` cycle → no new redirect, counter unchanged.
- Reset mid-flush with 3 queued entries → next cycle all outputs 0 and queue empty.
